// File: rtl/cpu_pkg.sv
// Shared types for the sequential RV64I control path: FSM states,
// major opcode values and the instruction classes the sequencer acts on.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_REDIRECT,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_class_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_ALU_IMM  = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG  = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMMW = 7'b0011011;
  localparam logic [6:0] OP_ALU_REGW = 7'b0111011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps instruction[6:0] to the class the
// sequencer uses to choose its path, and flags unknown opcodes.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_e cls,
  output logic         illegal
);

  // Opcode to class lookup; anything not listed is illegal.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_LOAD:          cls = CLS_LOAD;
      OP_STORE:         cls = CLS_STORE;
      OP_BRANCH:        cls = CLS_BRANCH;
      OP_JAL, OP_JALR:  cls = CLS_JUMP;
      OP_ALU_IMM, OP_ALU_REG, OP_ALU_IMMW,
      OP_ALU_REGW, OP_LUI, OP_AUIPC:
                        cls = CLS_ALU;
      OP_SYSTEM:        cls = CLS_SYSTEM;
      default:          cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the sequential RV64I core. Walks each
// instruction through fetch/decode/execute/memory/writeback, inserts a
// redirect cycle for taken transfers, handshakes with data memory (with a
// timeout) and counts retired instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [31:0]      instruction,
  input  logic             branch_cond,
  input  logic [63:0]      target_in,
  input  logic             mem_ready,
  output logic             fetch_stall,
  output logic             branch_taken,
  output logic [63:0]      branch_target_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write_en,
  output logic             halted,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q;
  state_e             state_d;
  instr_class_e       cls_q;
  instr_class_e       dec_cls;
  logic               dec_illegal;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               mem_timeout;
  logic               retire;
  logic               set_illegal;
  logic               set_bus_err;
  logic               clr_flags;

  // Only the major opcode steers sequencing; the remaining bits belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:7];

  instr_class_decode u_decode (
    .opcode  (instruction[6:0]),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // Last permitted wait cycle: a low mem_ready here ends the access with a bus error.
  assign mem_timeout = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, plus the retire and flag strobes tied to transitions.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    clr_flags   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_cls == CLS_SYSTEM) begin
          state_d = ST_HALT;
          retire  = 1'b1;
        end else if (dec_illegal) begin
          state_d     = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          CLS_ALU, CLS_JUMP:   state_d = ST_WRITEBACK;
          CLS_BRANCH: begin
            if (branch_cond) begin
              state_d = ST_REDIRECT;
            end else begin
              retire  = 1'b1;
              state_d = halt_req ? ST_IDLE : ST_FETCH;
            end
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEMORY: begin
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            retire  = 1'b1;
            state_d = halt_req ? ST_IDLE : ST_FETCH;
          end
        end else if (mem_timeout) begin
          state_d     = ST_HALT;
          set_bus_err = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        if (cls_q == CLS_JUMP) begin
          state_d = ST_REDIRECT;
        end else begin
          retire  = 1'b1;
          state_d = halt_req ? ST_IDLE : ST_FETCH;
        end
      end
      ST_REDIRECT: begin
        retire  = 1'b1;
        state_d = halt_req ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          clr_flags = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the current state.
  always_comb begin
    fetch_stall  = 1'b1;
    branch_taken = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write_en = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_FETCH:     fetch_stall = 1'b0;
      ST_MEMORY: begin
        mem_read  = (cls_q == CLS_LOAD);
        mem_write = (cls_q == CLS_STORE);
      end
      ST_WRITEBACK: reg_write_en = 1'b1;
      ST_REDIRECT: begin
        fetch_stall  = 1'b0;
        branch_taken = 1'b1;
      end
      ST_HALT:      halted = 1'b1;
      default:      fetch_stall = 1'b1;
    endcase
  end

  // Latch the instruction class while the fetched word is valid in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cls_q <= CLS_ALU;
    else if (state_q == ST_DECODE) cls_q <= dec_cls;
  end

  // Memory wait counter: runs only while a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt_q <= '0;
    else if (state_q == ST_MEMORY) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    else                           wait_cnt_q <= '0;
  end

  // Redirect target captured while the ALU result is valid in EXECUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     branch_target_addr <= '0;
    else if (state_q == ST_EXECUTE) branch_target_addr <= target_in;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Sticky error flags, cleared only when restarting out of HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else if (clr_flags) begin
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if (set_illegal) illegal_instr <= 1'b1;
      if (set_bus_err) bus_error     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver issues instructions and
// pushes the events a behavioural model predicts; a monitor pops and
// compares whenever the DUT shows a memory access end, writeback, redirect,
// retire or halt.
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  localparam int EV_MEM  = 0;
  localparam int EV_WB   = 1;
  localparam int EV_RDR  = 2;
  localparam int EV_RET  = 3;
  localparam int EV_HALT = 4;

  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_SYS = 5, C_ILL = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             halt_req;
  logic [31:0]      instruction;
  logic             branch_cond;
  logic [63:0]      target_in;
  logic             mem_ready = 1'b0;
  logic             fetch_stall;
  logic             branch_taken;
  logic [63:0]      branch_target_addr;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write_en;
  logic             halted;
  logic             illegal_instr;
  logic             bus_error;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .halt_req           (halt_req),
    .instruction        (instruction),
    .branch_cond        (branch_cond),
    .target_in          (target_in),
    .mem_ready          (mem_ready),
    .fetch_stall        (fetch_stall),
    .branch_taken       (branch_taken),
    .branch_target_addr (branch_target_addr),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .reg_write_en       (reg_write_en),
    .halted             (halted),
    .illegal_instr      (illegal_instr),
    .bus_error          (bus_error),
    .instret            (instret)
  );

  typedef struct {
    int          kind;
    logic [63:0] v0;
    int          v1;
  } ev_t;

  ev_t             exp_q[$];
  int              checks = 0;
  int              errors = 0;
  longint unsigned exp_cnt = 0;
  int              mem_delay = 0;

  function automatic void push_ev(int k, logic [63:0] a, int b);
    ev_t e;
    e.kind = k;
    e.v0   = a;
    e.v1   = b;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(int k, logic [63:0] a, int b, string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event v0=%0h v1=%0d, no event required", nm, a, b);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.v0 != a || e.v1 != b) begin
      errors++;
      $display("FAIL %s: got kind=%0d v0=%0h v1=%0d, required kind=%0d v0=%0h v1=%0d",
               nm, k, a, b, e.kind, e.v0, e.v1);
    end
  endfunction

  function automatic void check_val(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  function automatic int cls_of(logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111, 7'b1100111: return C_JMP;
      7'b0010011, 7'b0110011, 7'b0011011,
      7'b0111011, 7'b0110111, 7'b0010111: return C_ALU;
      7'b1110011: return C_SYS;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [63:0] cnt64();
    logic [CNT_W-1:0] c;
    c = exp_cnt[CNT_W-1:0];
    return 64'(c);
  endfunction

  // Reference model: predicted event list per instruction; returns 1 when it ends in HALT.
  function automatic bit model(logic [31:0] instr, logic cond, logic [63:0] tgt, int d);
    int c;
    bit to;
    c  = cls_of(instr[6:0]);
    to = (d < 0) || (d >= MEM_TIMEOUT);
    case (c)
      C_ALU: begin
        push_ev(EV_WB, 0, 0);
        exp_cnt++; push_ev(EV_RET, cnt64(), 4);
      end
      C_BR: begin
        if (cond) begin
          push_ev(EV_RDR, tgt, 0);
          exp_cnt++; push_ev(EV_RET, cnt64(), 4);
        end else begin
          exp_cnt++; push_ev(EV_RET, cnt64(), 3);
        end
      end
      C_JMP: begin
        push_ev(EV_WB, 0, 0);
        push_ev(EV_RDR, tgt, 0);
        exp_cnt++; push_ev(EV_RET, cnt64(), 5);
      end
      C_LOAD, C_STORE: begin
        if (to) begin
          push_ev(EV_MEM, (c == C_STORE) ? 64'd1 : 64'd0, MEM_TIMEOUT);
          push_ev(EV_HALT, 64'b01, int'(cnt64()));
          return 1'b1;
        end
        push_ev(EV_MEM, (c == C_STORE) ? 64'd1 : 64'd0, d + 1);
        if (c == C_LOAD) begin
          push_ev(EV_WB, 0, 0);
          exp_cnt++; push_ev(EV_RET, cnt64(), 5 + d);
        end else begin
          exp_cnt++; push_ev(EV_RET, cnt64(), 4 + d);
        end
      end
      C_SYS: begin
        exp_cnt++; push_ev(EV_RET, cnt64(), 2);
        push_ev(EV_HALT, 64'b00, int'(cnt64()));
        return 1'b1;
      end
      default: begin
        push_ev(EV_HALT, 64'b10, int'(cnt64()));
        return 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  // Memory responder: raises mem_ready in request cycle number mem_delay (never if negative).
  int rq = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (mem_read || mem_write)) begin
      mem_ready = (mem_delay >= 0) && (rq == mem_delay);
      rq++;
    end else begin
      mem_ready = 1'b0;
      rq = 0;
    end
  end

  // Monitor: turns DUT activity into events and checks them against the queue.
  int               cyc = 0;
  int               last_fetch = 0;
  int               req_n = 0;
  logic             req_w = 1'b0;
  logic [CNT_W-1:0] prev_ir = '0;
  logic             prev_halted = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      req_n       = 0;
      prev_ir     = '0;
      prev_halted = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        req_n++;
        req_w = mem_write;
      end else if (req_n != 0) begin
        check_ev(EV_MEM, 64'(req_w), req_n, "mem_access");
        req_n = 0;
      end
      if (reg_write_en) check_ev(EV_WB, 0, 0, "writeback");
      if (branch_taken) check_ev(EV_RDR, branch_target_addr, int'(fetch_stall), "redirect");
      if (instret != prev_ir) begin
        check_ev(EV_RET, 64'(instret), cyc - last_fetch, "retire");
        prev_ir = instret;
      end
      if (halted && !prev_halted)
        check_ev(EV_HALT, {62'd0, illegal_instr, bus_error}, int'(instret), "halt");
      prev_halted = halted;
      if (!fetch_stall && !branch_taken) last_fetch = cyc;
    end
  end

  task automatic bail(string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required DUT event", nm);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "bench aborted");
  endtask

  task automatic check_reset_vals(string tag);
    check_val({tag, "_fetch_stall"}, 64'(fetch_stall), 64'd1);
    check_val({tag, "_branch_taken"}, 64'(branch_taken), 64'd0);
    check_val({tag, "_target"}, branch_target_addr, 64'd0);
    check_val({tag, "_mem_rw"}, {62'd0, mem_read, mem_write}, 64'd0);
    check_val({tag, "_reg_write"}, 64'(reg_write_en), 64'd0);
    check_val({tag, "_halted"}, 64'(halted), 64'd0);
    check_val({tag, "_flags"}, {62'd0, illegal_instr, bus_error}, 64'd0);
    check_val({tag, "_instret"}, 64'(instret), 64'd0);
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!(fetch_stall == 1'b0 && branch_taken == 1'b0)) begin
      @(negedge clk);
      n++;
      if (n > 200) bail("fetch_wait");
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic cond, input logic [63:0] tgt,
                       input int d, input bit hreq);
    bit               h;
    int               n;
    logic [CNT_W-1:0] old;
    wait_fetch();
    instruction = instr;
    branch_cond = cond;
    target_in   = tgt;
    mem_delay   = d;
    h = model(instr, cond, tgt, d);
    @(negedge clk);
    if (h) begin
      n = 0;
      while (!halted) begin
        @(negedge clk);
        n++;
        if (n > 60) bail("halt_wait");
      end
      @(negedge clk);
      pulse_start();
      check_val("flags_cleared", {62'd0, illegal_instr, bus_error}, 64'd0);
    end else if (hreq) begin
      @(negedge clk);
      halt_req = 1'b1;
      old = instret;
      n = 0;
      while (instret == old) begin
        @(negedge clk);
        n++;
        if (n > 60) bail("retire_wait");
      end
      halt_req = 1'b0;
      repeat (2) begin
        check_val("idle_after_halt_req", {61'd0, fetch_stall, halted, branch_taken}, 64'b100);
        @(negedge clk);
      end
      pulse_start();
    end
  endtask

  logic [6:0] alu_ops [6] = '{7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011, 7'b0110111, 7'b0010111};

  initial begin
    #300000;
    bail("global_timeout");
  end

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    int          r;
    int          d;
    rst_n       = 1'b0;
    start       = 1'b0;
    halt_req    = 1'b0;
    instruction = 32'h0;
    branch_cond = 1'b0;
    target_in   = 64'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_stall", {62'd0, fetch_stall, halted}, 64'b10);
    pulse_start();

    // Directed sequence.
    issue(32'h0000_0013, 1'b0, 64'h0, 0, 1'b0);                 // ADDI
    issue(32'h0000_0063, 1'b1, 64'h40, 0, 1'b0);                // BEQ taken
    issue(32'h0000_2003, 1'b0, 64'h100, 3, 1'b0);               // LW, 3 wait cycles
    issue(32'h0000_2023, 1'b0, 64'h0, 15, 1'b0);                // SW, ready on last allowed cycle
    issue(32'h0000_2023, 1'b0, 64'h0, -1, 1'b0);                // SW, timeout
    issue(32'h0000_0000, 1'b0, 64'h0, 0, 1'b0);                 // illegal
    issue(32'h0000_006f, 1'b0, 64'h1234_5678_9abc_def0, 0, 1'b0); // JAL
    issue(32'h0000_0063, 1'b0, 64'h80, 0, 1'b0);                // BEQ not taken
    issue(32'h0000_0073, 1'b0, 64'h0, 0, 1'b0);                 // ECALL
    issue(32'h0000_3003, 1'b0, 64'h0, 16, 1'b0);                // LD, ready one cycle too late
    issue(32'h0000_0067, 1'b0, 64'hffff_ffff_ffff_fff8, 0, 1'b0); // JALR

    // Randomized sequence.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      case (r)
        3: w[6:0] = 7'b1100011;
        4: w[6:0] = ($urandom_range(0, 1) == 1) ? 7'b1101111 : 7'b1100111;
        5: w[6:0] = 7'b0000011;
        6: w[6:0] = 7'b0100011;
        7: w[6:0] = 7'b1110011;
        8: begin
          op = 7'(($urandom_range(0, 127)));
          while (cls_of(op) != C_ILL) op = 7'(($urandom_range(0, 127)));
          w[6:0] = op;
        end
        default: w[6:0] = alu_ops[$urandom_range(0, 5)];
      endcase
      issue(w, 1'($urandom_range(0, 1)), {$urandom, $urandom}, d, ($urandom_range(0, 5) == 0));
    end

    // halt_req during EXECUTE of an ADDI: retires, then IDLE.
    issue(32'h0010_0093, 1'b0, 64'h0, 0, 1'b1);

    // Reset dropped while a load waits in MEMORY.
    wait_fetch();
    instruction = 32'h0000_2003;
    branch_cond = 1'b0;
    target_in   = 64'hdead_beef;
    mem_delay   = -1;
    begin
      int n;
      n = 0;
      while (!mem_read) begin
        @(negedge clk);
        n++;
        if (n > 20) bail("mem_req_wait");
      end
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_delay = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("after_reset");
    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the sequential RV64I core. It owns the `stall`, `branch_taken` and `branch_target_addr` inputs of the instruction-fetch stage and walks every instruction through FETCH → DECODE → EXECUTE → (MEMORY) → (WRITEBACK). It also inserts a PC-redirect cycle for taken control transfers, handshakes with data memory and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, 16: max cycles spent waiting for `mem_ready` before a bus-error halt.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: leave IDLE/HALT and begin fetching.
- `halt_req` in 1: stop at the next instruction boundary.
- `instruction` in 32: fetched word from the fetch stage.
- `branch_cond` in 1: ALU compare result, valid in EXECUTE.
- `target_in` in 64: computed branch/jump target, valid in EXECUTE.
- `mem_ready` in 1: data-memory completion strobe.
- `fetch_stall` out 1: stall to the fetch stage.
- `branch_taken` out 1: redirect to the fetch stage.
- `branch_target_addr` out 64: registered redirect target.
- `mem_read` out 1: data-memory read request.
- `mem_write` out 1: data-memory write request.
- `reg_write_en` out 1: register-file write strobe.
- `halted` out 1: FSM is in HALT.
- `illegal_instr` out 1: sticky flag, unknown opcode.
- `bus_error` out 1: sticky flag, memory timeout.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, REDIRECT, HALT. All outputs are Moore-decoded from the state register, except `branch_target_addr`, `instret` and the flags, which are registered.
- Opcode classes from `instruction[6:0]`:
  - LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111.
  - ALU: 0010011, 0110011, 0011011, 0111011, 0110111, 0010111.
  - SYSTEM 1110011.
  - Anything else is illegal.
- IDLE: `fetch_stall`=1. On `start` → FETCH.
- FETCH: `fetch_stall`=0 for exactly one cycle, so fetch latches the word and advances PC. → DECODE.
- DECODE: latch the opcode class.
  - SYSTEM → HALT.
  - Illegal → HALT and set `illegal_instr`.
  - Otherwise → EXECUTE.
- EXECUTE: latch `target_in` into `branch_target_addr`.
  - LOAD/STORE → MEMORY.
  - ALU → WRITEBACK.
  - JAL/JALR → WRITEBACK with redirect pending.
  - BRANCH with `branch_cond`=1 → REDIRECT; with `branch_cond`=0 → boundary.
- MEMORY: assert `mem_read` (LOAD) or `mem_write` (STORE) continuously until `mem_ready`.
  - LOAD → WRITEBACK; STORE → boundary.
  - Wait counter reaching MEM_TIMEOUT → HALT, set `bus_error`, drop the request.
- WRITEBACK: `reg_write_en`=1 for one cycle. → REDIRECT if redirect pending, else boundary.
- REDIRECT: `fetch_stall`=0 and `branch_taken`=1 for one cycle. This discards the word loaded in that cycle and sets PC to the target. → FETCH.
- Boundary (instruction complete):
  - `instret` += 1, wrapping modulo 2^CNT_W.
  - Next state is IDLE if `halt_req`, else FETCH.
  - Taken branches and jumps retire on leaving REDIRECT.
- HALT: `fetch_stall`=1. On `start` → FETCH and clear both sticky flags. SYSTEM instructions retire on HALT entry; illegal and bus-error instructions do not retire.
- Simultaneous `start` and `halt_req` in IDLE: `start` wins.
- `halt_req` is ignored mid-instruction.

## Timing
- Reset values: state IDLE, `fetch_stall`=1, `branch_taken`=0, `branch_target_addr`=0, `mem_read`=`mem_write`=`reg_write_en`=0, `halted`=0, flags 0, `instret`=0.
- An `rst_n` assertion mid-instruction aborts immediately with no retire.
- `instruction` is valid in DECODE, one cycle after FETCH.
- Cycles per instruction (w = extra `mem_ready` wait cycles):
  - ALU: 4.
  - Branch not taken: 3; branch taken: 4.
  - JAL/JALR: 5.
  - STORE: 4+w; LOAD: 5+w.
- `mem_ready` sampled high in the first MEMORY cycle completes with w=0.
- Timeout fires after MEM_TIMEOUT request cycles with `mem_ready` low.

## Structure
- Shared package `cpu_pkg` holds the state enum, opcode constants and the opcode-class enum.
- Sub-module `instr_class_decode` (combinational): opcode → class and illegal flag.

## Test plan
- Reset, then `start` with word 0x00000013 (ADDI): state sequence F,D,E,W,F; `reg_write_en` high 1 cycle; `instret`=1 after 4 cycles.
- BEQ with `branch_cond`=1 and `target_in`=0x40: REDIRECT cycle shows `fetch_stall`=0, `branch_taken`=1, `branch_target_addr`=0x40; next FETCH follows.
- LW with `mem_ready` delayed 3 cycles: `mem_read` high 4 cycles, then WRITEBACK; 8 cycles total.
- SW with `mem_ready` never asserted and MEM_TIMEOUT=16: after 16 request cycles, `bus_error`=1, `halted`=1, `instret` unchanged.
- Opcode 0000000: `illegal_instr`=1, HALT; then `start` clears the flag and fetching resumes.
- `halt_req` raised during EXECUTE of an ADDI: instruction retires, FSM enters IDLE; `rst_n` dropped in MEMORY forces all outputs to reset values.
